scs8hd_a2111oi_bist: RTL and testbench

//  Drives an a2111oi-family cell with all 32 input vectors and captures its Y.

---
 rtl/scs8hd_bist_pkg.sv | 48 ++++
 rtl/scs8hd_bist_misr.sv | 52 +++++
 rtl/scs8hd_a2111oi_bist.sv | 205 ++++++++++++++++++++
 tb/tb_scs8hd_a2111oi_bist.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scs8hd_bist_pkg.sv
// ============================================================================
//  Module      : scs8hd_bist_pkg
//  Description : Shared definitions for the a2111oi cell BIST: FSM state
//                encoding, MISR feedback taps and the golden cell function.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package scs8hd_bist_pkg;

   // Sequencer states: one vector window is APPLY, SETTLE x WAIT, CAPTURE.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_APPLY   = 3'd1,
      ST_WAIT    = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

   // Signature register width; the feedback polynomial below is only
   // defined for this width.
   localparam int MISR_W = 16;

   // Polynomial x^16 + x^15 + x^13 + x^4 + 1, expressed as the register
   // bits that feed the shift-in XOR: bits 15, 14, 12 and 3.
   localparam logic [MISR_W-1:0] MISR_TAPS = 16'hD008;

   // Number of exhaustive input vectors for a five-input cell.
   localparam int NUM_VEC = 32;

   // Golden response of the cell for vector {A1,A2,B1,C1,D1}.
   function automatic logic a2111oi_golden(input logic [4:0] vec);
      logic a1;
      logic a2;
      logic b1;
      logic c1;
      logic d1;
      a1 = vec[4];
      a2 = vec[3];
      b1 = vec[2];
      c1 = vec[1];
      d1 = vec[0];
      return ~((a1 & a2) | b1 | c1 | d1);
   endfunction

endpackage : scs8hd_bist_pkg

`default_nettype wire

// File: rtl/scs8hd_bist_misr.sv
// ============================================================================
//  Module      : scs8hd_bist_misr
//  Description : 16-bit multiple-input signature register. Single serial
//                input XORed into bit 0 after each shift. Synchronous clear
//                has priority over enable; reset is asynchronous active-low.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module scs8hd_bist_misr
   import scs8hd_bist_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clr_i,
   input  logic              en_i,
   input  logic              din_i,
   output logic [MISR_W-1:0] sig_o
);

   logic [MISR_W-1:0] sig_q;
   logic [MISR_W-1:0] sig_d;
   logic              w_feedback;

   // Parity of the tapped bits forms the bit shifted in at the bottom.
   assign w_feedback = ^(sig_q & MISR_TAPS);

   // Next signature: clear wins, otherwise shift with feedback and fold in
   // the serial response bit.
   always_comb begin
      sig_d = sig_q;
      if (clr_i) begin
         sig_d = '0;
      end else if (en_i) begin
         sig_d = {sig_q[MISR_W-2:0], w_feedback} ^ {{(MISR_W-1){1'b0}}, din_i};
      end
   end

   // Signature register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig_o = sig_q;

endmodule : scs8hd_bist_misr

`default_nettype wire

// File: rtl/scs8hd_a2111oi_bist.sv
// ============================================================================
//  Module      : scs8hd_a2111oi_bist
//  Description : Exhaustive BIST for an a2111oi cell. Applies all 32 input
//                vectors, samples Y_IN after SETTLE idle cycles, compares
//                against the golden function, counts mismatches, records the
//                first failing vector and compacts every response in a MISR.
//  Options     : SCS8HD_BIST_XCHK_EN - simulation-only X/Z-aware compare;
//                an unknown response counts as a mismatch and enters the
//                signature as 1.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module scs8hd_a2111oi_bist
   import scs8hd_bist_pkg::*;
#(
   parameter int SETTLE = 2,
   parameter int SIG_W  = 16,
   parameter int CNT_W  = 8
) (
   input  logic             CLK,
   input  logic             RESETB,
   input  logic             START,
   input  logic             ABORT,
   input  logic             Y_IN,
   output logic             A1,
   output logic             A2,
   output logic             B1,
   output logic             C1,
   output logic             D1,
   output logic             BUSY,
   output logic             DONE,
   output logic             PASS,
   output logic [CNT_W-1:0] FAIL_CNT,
   output logic [4:0]       FAIL_VEC,
   output logic [SIG_W-1:0] SIG
);

   // Wait counter only needs to reach SETTLE-1; keep at least one bit so the
   // SETTLE=0 build still has a legal (unused) register.
   localparam int c_WCNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [c_WCNT_W-1:0] c_WAIT_LAST =
      c_WCNT_W'((SETTLE > 0) ? (SETTLE - 1) : 0);
   localparam logic [4:0] c_LAST_VEC = 5'(NUM_VEC - 1);

   state_e              state_q;
   state_e              state_d;
   logic [4:0]          vec_q;
   logic [4:0]          vec_d;
   logic [c_WCNT_W-1:0] wcnt_q;
   logic [c_WCNT_W-1:0] wcnt_d;
   logic [CNT_W-1:0]    fail_cnt_q;
   logic [CNT_W-1:0]    fail_cnt_d;
   logic [4:0]          fail_vec_q;
   logic [4:0]          fail_vec_d;
   logic                fail_seen_q;
   logic                fail_seen_d;

   logic                w_busy;
   logic                w_mismatch;
   logic                w_misr_bit;
   logic                w_misr_clr;
   logic                w_misr_en;
   logic [MISR_W-1:0]   w_sig;

   // ------------------------------------------------------------------
   // Response compare
   // ------------------------------------------------------------------
`ifdef SCS8HD_BIST_XCHK_EN
   // Four-state compare: an undriven or unknown Y counts as a failure and
   // is forced to 1 so the signature stays fully known.
   assign w_mismatch = (Y_IN !== a2111oi_golden(vec_q));
   assign w_misr_bit = (Y_IN === 1'b0) ? 1'b0 : 1'b1;
`else
   // Plain compare: an unknown Y propagates into the count and signature.
   assign w_mismatch = (Y_IN != a2111oi_golden(vec_q));
   assign w_misr_bit = Y_IN;
`endif

   // ------------------------------------------------------------------
   // Sequencer
   // ------------------------------------------------------------------

   // Next-state and datapath updates; ABORT takes priority over START and
   // also suppresses the compare on a CAPTURE cycle.
   always_comb begin
      state_d     = state_q;
      vec_d       = vec_q;
      wcnt_d      = wcnt_q;
      fail_cnt_d  = fail_cnt_q;
      fail_vec_d  = fail_vec_q;
      fail_seen_d = fail_seen_q;
      w_misr_clr  = 1'b0;
      w_misr_en   = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (START && !ABORT) begin
               state_d     = ST_APPLY;
               vec_d       = '0;
               fail_cnt_d  = '0;
               fail_vec_d  = '0;
               fail_seen_d = 1'b0;
               w_misr_clr  = 1'b1;
            end
         end

         ST_APPLY: begin
            if (ABORT) begin
               state_d = ST_IDLE;
            end else begin
               wcnt_d  = '0;
               state_d = (SETTLE > 0) ? ST_WAIT : ST_CAPTURE;
            end
         end

         ST_WAIT: begin
            if (ABORT) begin
               state_d = ST_IDLE;
            end else if (wcnt_q == c_WAIT_LAST) begin
               state_d = ST_CAPTURE;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end

         ST_CAPTURE: begin
            if (ABORT) begin
               state_d = ST_IDLE;
            end else begin
               w_misr_en = 1'b1;
               // Adding the compare result keeps an unknown Y visible.
               if (fail_cnt_q != '1) begin
                  fail_cnt_d = fail_cnt_q + CNT_W'(w_mismatch);
               end
               if (w_mismatch && !fail_seen_q) begin
                  fail_vec_d  = vec_q;
                  fail_seen_d = 1'b1;
               end
               if (vec_q == c_LAST_VEC) begin
                  state_d = ST_DONE;
               end else begin
                  vec_d   = vec_q + 5'd1;
                  state_d = ST_APPLY;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sequencer and result registers.
   always_ff @(posedge CLK or negedge RESETB) begin
      if (!RESETB) begin
         state_q     <= ST_IDLE;
         vec_q       <= '0;
         wcnt_q      <= '0;
         fail_cnt_q  <= '0;
         fail_vec_q  <= '0;
         fail_seen_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         vec_q       <= vec_d;
         wcnt_q      <= wcnt_d;
         fail_cnt_q  <= fail_cnt_d;
         fail_vec_q  <= fail_vec_d;
         fail_seen_q <= fail_seen_d;
      end
   end

   // ------------------------------------------------------------------
   // Signature register
   // ------------------------------------------------------------------
   scs8hd_bist_misr u_misr (
      .clk_i  (CLK),
      .rst_ni (RESETB),
      .clr_i  (w_misr_clr),
      .en_i   (w_misr_en),
      .din_i  (w_misr_bit),
      .sig_o  (w_sig)
   );

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign w_busy = (state_q == ST_APPLY) || (state_q == ST_WAIT) ||
                   (state_q == ST_CAPTURE);

   // Stimulus follows the vector register for the whole window and is
   // forced low whenever no run is active.
   assign {A1, A2, B1, C1, D1} = w_busy ? vec_q : 5'd0;

   assign BUSY     = w_busy;
   assign DONE     = (state_q == ST_DONE);
   assign PASS     = (state_q == ST_DONE) && (fail_cnt_q == '0);
   assign FAIL_CNT = fail_cnt_q;
   assign FAIL_VEC = fail_vec_q;
   assign SIG      = SIG_W'(w_sig);

endmodule : scs8hd_a2111oi_bist

`default_nettype wire

// File: tb/tb_scs8hd_a2111oi_bist.sv
// ============================================================================
//  Module      : tb_scs8hd_a2111oi_bist
//  Description : Self-checking bench for scs8hd_a2111oi_bist. The bench
//                plays the cell under test (good, stuck, or randomly
//                faulty) and predicts each run's results from a vector-level
//                model of the expected BIST behaviour.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_scs8hd_a2111oi_bist;

   localparam int c_SETTLE = 2;
   localparam int c_BUSY   = 32 * (c_SETTLE + 2);

   logic       CLK = 1'b0;
   logic       RESETB;
   logic       START;
   logic       ABORT;
   logic       Y_IN;
   logic       A1, A2, B1, C1, D1;
   logic       BUSY, DONE, PASS;
   logic [7:0] FAIL_CNT;
   logic [4:0] FAIL_VEC;
   logic [15:0] SIG;

   int         n_assert = 0;
   int         n_fail   = 0;
   int         mode     = 0;      // 0 good, 1 stuck-0, 2 stuck-1, 3 flip mask
   bit [31:0]  flip     = '0;
   int         stim_bad = 0;

   scs8hd_a2111oi_bist #(
      .SETTLE (c_SETTLE),
      .SIG_W  (16),
      .CNT_W  (8)
   ) dut (
      .CLK      (CLK),
      .RESETB   (RESETB),
      .START    (START),
      .ABORT    (ABORT),
      .Y_IN     (Y_IN),
      .A1       (A1),
      .A2       (A2),
      .B1       (B1),
      .C1       (C1),
      .D1       (D1),
      .BUSY     (BUSY),
      .DONE     (DONE),
      .PASS     (PASS),
      .FAIL_CNT (FAIL_CNT),
      .FAIL_VEC (FAIL_VEC),
      .SIG      (SIG)
   );

   always #5 CLK = ~CLK;

   // Truth table of the ideal cell.
   function automatic bit golden(input bit [4:0] v);
      return !((v[4] && v[3]) || v[2] || v[1] || v[0]);
   endfunction

   // Behaviour of the emulated cell under test.
   function automatic bit cell_y(input bit [4:0] v, input int m, input bit [31:0] f);
      case (m)
         1:       return 1'b0;
         2:       return 1'b1;
         3:       return golden(v) ^ f[v];
         default: return golden(v);
      endcase
   endfunction

   always_comb Y_IN = cell_y({A1, A2, B1, C1, D1}, mode, flip);

   // Expected results after the first nvec vectors have been captured.
   task automatic model(input int m, input bit [31:0] f, input int nvec,
                        output int ecnt, output int evec, output int esig);
      int fb;
      int y;
      bit seen;
      ecnt = 0;
      evec = 0;
      esig = 0;
      seen = 0;
      for (int v = 0; v < nvec; v++) begin
         y = int'(cell_y(5'(v), m, f));
         if (y != int'(golden(5'(v)))) begin
            if (ecnt < 255) ecnt++;
            if (!seen) begin
               seen = 1;
               evec = v;
            end
         end
         fb   = ((esig >> 15) ^ (esig >> 14) ^ (esig >> 12) ^ (esig >> 3)) & 1;
         esig = (((esig << 1) | fb) & 32'hFFFF) ^ y;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   // Starts a run and follows it until BUSY drops (bounded), checking the
   // stimulus against the vector implied by the cycle index.
   task automatic run(input int pulse_at, output int busy_cycles);
      START = 1'b1;
      tick();
      START = 1'b0;
      busy_cycles = 0;
      stim_bad    = 0;
      while (BUSY && busy_cycles < 1000) begin
         if ({A1, A2, B1, C1, D1} !== 5'(busy_cycles / (c_SETTLE + 2))) stim_bad++;
         START = (busy_cycles == pulse_at);
         tick();
         busy_cycles++;
      end
      START = 1'b0;
   endtask

   task automatic full_run(input string tag, input int m, input bit [31:0] f,
                           input int pulse_at);
      int bc, ecnt, evec, esig;
      mode = m;
      flip = f;
      model(m, f, 32, ecnt, evec, esig);
      run(pulse_at, bc);
      chk({tag, " busy_cycles"}, 32'(bc), 32'(c_BUSY));
      chk({tag, " stim"}, 32'(stim_bad), 32'd0);
      chk({tag, " done"}, 32'(DONE), 32'd1);
      chk({tag, " pass"}, 32'(PASS), 32'(ecnt == 0));
      chk({tag, " fail_cnt"}, 32'(FAIL_CNT), 32'(ecnt));
      chk({tag, " fail_vec"}, 32'(FAIL_VEC), 32'(evec));
      chk({tag, " sig"}, 32'(SIG), 32'(esig));
      chk({tag, " stim_idle"}, 32'({A1, A2, B1, C1, D1}), 32'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " busy"}, 32'(BUSY), 32'd0);
      chk({tag, " done"}, 32'(DONE), 32'd0);
      chk({tag, " pass"}, 32'(PASS), 32'd0);
      chk({tag, " fail_cnt"}, 32'(FAIL_CNT), 32'd0);
      chk({tag, " fail_vec"}, 32'(FAIL_VEC), 32'd0);
      chk({tag, " sig"}, 32'(SIG), 32'd0);
      chk({tag, " stim"}, 32'({A1, A2, B1, C1, D1}), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ecnt, evec, esig;

      // Reset
      RESETB = 1'b0;
      START  = 1'b0;
      ABORT  = 1'b0;
      repeat (3) tick();
      chk_all_zero("reset");
      RESETB = 1'b1;
      tick();
      chk_all_zero("post_reset");

      // Good cell, stuck-at-0, stuck-at-1
      full_run("good", 0, 32'd0, -1);
      full_run("stuck0", 1, 32'd0, -1);
      full_run("stuck1", 2, 32'd0, -1);

      // Randomly faulty cells
      for (int r = 0; r < 3; r++) begin
         full_run($sformatf("rand%0d", r), 3, 32'($urandom), -1);
      end

      // ABORT on cycle 10 with a stuck-at-1 cell: two vectors captured
      mode = 2;
      flip = '0;
      model(2, 32'd0, 2, ecnt, evec, esig);
      START = 1'b1;
      tick();
      START = 1'b0;
      repeat (10) tick();
      ABORT = 1'b1;
      tick();
      ABORT = 1'b0;
      chk("abort busy", 32'(BUSY), 32'd0);
      chk("abort done", 32'(DONE), 32'd0);
      chk("abort stim", 32'({A1, A2, B1, C1, D1}), 32'd0);
      chk("abort fail_cnt", 32'(FAIL_CNT), 32'(ecnt));
      chk("abort fail_vec", 32'(FAIL_VEC), 32'(evec));
      chk("abort sig", 32'(SIG), 32'(esig));

      // START together with ABORT in IDLE: nothing moves
      START = 1'b1;
      ABORT = 1'b1;
      tick();
      START = 1'b0;
      ABORT = 1'b0;
      tick();
      chk("start_abort busy", 32'(BUSY), 32'd0);
      chk("start_abort done", 32'(DONE), 32'd0);
      chk("start_abort fail_cnt", 32'(FAIL_CNT), 32'(ecnt));
      chk("start_abort sig", 32'(SIG), 32'(esig));

      // Clean re-run after abort, with a START pulse mid-run
      full_run("rerun", 0, 32'd0, 5);

      // RESETB low at cycle 50 of a stuck-at-0 run
      mode = 1;
      START = 1'b1;
      tick();
      START = 1'b0;
      repeat (50) tick();
      RESETB = 1'b0;
      #1;
      chk_all_zero("midrun_reset");
      repeat (3) tick();
      RESETB = 1'b1;
      tick();
      chk_all_zero("after_reset");

      // A run after reset still completes normally
      full_run("final", 3, 32'($urandom), -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_scs8hd_a2111oi_bist

`default_nettype wire
